spi_sram_responder: RTL and testbench

Synthesizable SPI-mode-0 SRAM responder: the target side of the serial link driven by spi_memory_controller. It replaces the behavioural SRAM model with clock-synchronous RTL. It decodes 23LC512-style commands (READ, WRITE, RDMR, WRMR) with a 16-bit address and translates them into a single-cycle byte-wide memory port. It serves on-chip RAM or FPGA bring-up and acts as a checkable model for cocotb.

---
 rtl/spi_sram_responder.sv | 175 +++++++++++++++++
 tb/tb_spi_sram_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_responder.sv
// SPI mode-0 SRAM target (23LC512 command set): oversamples the serial link on clk
// and turns READ/WRITE/RDMR/WRMR transactions into a single-cycle byte-wide memory port.
module spi_sram_responder #(
  parameter int         ADDR_W     = 16,
  parameter int         PAGE_SIZE  = 32,
  parameter logic [7:0] MODE_RESET = 8'h40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mode_reg,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_SIZE - 1);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, RDMR, WRMR, IGNORE
  } state_t;

  state_t      state;
  logic        cs_s1, cs_s2, cs_d;
  logic        sclk_s1, sclk_s2, sclk_d;
  logic        mosi_s1, mosi_s2;
  logic        sclk_rise, sclk_fall, cs_fall;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_shift, rx_next, tx_shift, tx_buf, tx_src, addr_hi;
  logic        is_read, rd_wait, byte_done, byte_mode, page_mode;
  logic [15:0] addr_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      {cs_s1, cs_s2, cs_d}       <= 3'b111;
      {sclk_s1, sclk_s2, sclk_d} <= 3'b000;
      {mosi_s1, mosi_s2}         <= 2'b00;
    end else begin
      cs_s1   <= spi_cs_n;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign cs_fall   = cs_d & ~cs_s2;
  assign rx_next   = {rx_shift[6:0], mosi_s2};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign addr_full = {addr_hi, rx_next};
  assign byte_mode = (mode_reg[7:6] == 2'b00);
  assign page_mode = (mode_reg[7:6] == 2'b10);
  assign tx_src    = (state == RDMR) ? mode_reg : tx_buf;

  // Page mode keeps the page number and only rolls the in-page offset.
  function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] a, input logic page);
    logic [ADDR_W-1:0] inc;
    inc = a + ADDR_W'(1);
    if (page) return (a & ~PAGE_MASK) | (inc & PAGE_MASK);
    return inc;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      tx_buf      <= 8'h00;
      addr_hi     <= 8'h00;
      is_read     <= 1'b0;
      rd_wait     <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
      mode_reg    <= MODE_RESET;
      busy        <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      rd_wait <= mem_re;
      busy    <= ~cs_s2;
      if (rd_wait) tx_buf <= mem_rdata;
      // The address moves on only after the write strobe has used it.
      if (mem_we && !byte_mode) mem_addr <= advance(mem_addr, page_mode);

      if (state != IDLE && cs_s2) begin
        state       <= IDLE;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        if (sclk_rise && state != IDLE) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 3'd1;
        end
        // A fall at bit 0 starts a fresh byte from the prefetched buffer.
        if (sclk_fall && (state == RD_DATA || state == RDMR)) begin
          spi_miso_oe <= 1'b1;
          if (bit_cnt == 3'd0) {spi_miso, tx_shift} <= {tx_src, 1'b0};
          else                 {spi_miso, tx_shift} <= {tx_shift, 1'b0};
        end

        case (state)
          IDLE: if (cs_fall) begin
            state   <= CMD;
            bit_cnt <= 3'd0;
          end
          CMD: if (byte_done) begin
            case (rx_next)
              8'h03:   begin is_read <= 1'b1; state <= ADDR_HI; end
              8'h02:   begin is_read <= 1'b0; state <= ADDR_HI; end
              8'h05:   state <= RDMR;
              8'h01:   state <= WRMR;
              default: state <= IGNORE;
            endcase
          end
          ADDR_HI: if (byte_done) begin
            addr_hi <= rx_next;
            state   <= ADDR_LO;
          end
          ADDR_LO: if (byte_done) begin
            mem_addr <= ADDR_W'(addr_full);
            if (is_read) begin
              mem_re <= 1'b1;
              state  <= RD_DATA;
            end else begin
              state  <= WR_DATA;
            end
          end
          RD_DATA: if (byte_done) begin
            if (byte_mode) begin
              state       <= IGNORE;
              spi_miso    <= 1'b0;
              spi_miso_oe <= 1'b0;
            end else begin
              mem_addr <= advance(mem_addr, page_mode);
              mem_re   <= 1'b1;
            end
          end
          WR_DATA: if (byte_done) begin
            mem_wdata <= rx_next;
            mem_we    <= 1'b1;
            if (byte_mode) state <= IGNORE;
          end
          RDMR: ;
          WRMR: if (byte_done) begin
            mode_reg <= rx_next;
            state    <= IGNORE;
          end
          IGNORE: begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: bit-banged SPI initiator, synchronous backing memory,
// and an address/byte reference model derived from the command and mode rules.
module tb_spi_sram_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs_n = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, mode_reg;
  logic        mem_we, mem_re, busy;

  int checks = 0;
  int errors = 0;
  int both_cnt = 0;

  logic [7:0]  mem [0:65535];
  logic        mem_written [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  ref_mode = 8'h40;
  logic [23:0] we_log[$];
  logic [15:0] re_log[$];
  logic [7:0]  tx_q[$], rx_q[$], dq[$];
  logic        oe_any_q[$], oe_all_q[$];
  logic        busy_mid;

  spi_sram_responder dut (
    .clk(clk), .reset(reset),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mode_reg(mode_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seedByte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Backing RAM: read data appears one clk after the strobe.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem_written[mem_addr] ? mem[mem_addr] : seedByte(mem_addr);
    if (mem_we) begin
      mem[mem_addr]         <= mem_wdata;
      mem_written[mem_addr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mem_we) we_log.push_back({mem_addr, mem_wdata});
    if (mem_re) re_log.push_back(mem_addr);
    if (mem_we && mem_re) both_cnt <= both_cnt + 1;
  end

  function automatic logic [15:0] refNext(input logic [15:0] a);
    int ai;
    ai = int'(a);
    if (ref_mode[7:6] == 2'b10) return 16'((ai / 32) * 32 + ((ai % 32) + 1) % 32);
    return 16'((ai + 1) % 65536);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spiBit(input logic b, output logic m, output logic oe);
    spi_mosi = b;
    repeat (HALF) @(posedge clk);
    #2;
    m = spi_miso;
    oe = spi_miso_oe;
    busy_mid = busy;
    spi_sclk = 1'b1;
    repeat (HALF) @(posedge clk);
    #2 spi_sclk = 1'b0;
  endtask

  // Sends tx_q, then an optional partial byte, then releases CS.
  task automatic applyStimulus(input int extra_bits, input logic [7:0] extra_val);
    logic m, oe, any, all;
    logic [7:0] r;
    rx_q.delete();
    oe_any_q.delete();
    oe_all_q.delete();
    @(posedge clk);
    #2 spi_cs_n = 1'b0;
    foreach (tx_q[k]) begin
      r = 8'h00; any = 1'b0; all = 1'b1;
      for (int i = 7; i >= 0; i--) begin
        spiBit(tx_q[k][i], m, oe);
        r[i] = m;
        any |= oe;
        all &= oe;
      end
      rx_q.push_back(r);
      oe_any_q.push_back(any);
      oe_all_q.push_back(all);
    end
    for (int i = 0; i < extra_bits; i++) spiBit(extra_val[7-i], m, oe);
    repeat (HALF) @(posedge clk);
    #2 spi_cs_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_miso_idle"}, 32'(spi_miso), 32'd0);
    checkOutput({tag, "_oe_idle"}, 32'(spi_miso_oe), 32'd0);
    checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_miso"}, 32'(spi_miso), 32'd0);
    checkOutput({tag, "_oe"}, 32'(spi_miso_oe), 32'd0);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_re"}, 32'(mem_re), 32'd0);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    checkOutput({tag, "_mode"}, 32'(mode_reg), 32'h40);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic setMode(input string tag, input logic [7:0] m);
    int wb, rb;
    wb = we_log.size();
    rb = re_log.size();
    tx_q = {8'h01, m};
    applyStimulus(0, 8'h00);
    ref_mode = m;
    checkOutput({tag, "_mode_reg"}, 32'(mode_reg), 32'(m));
    checkOutput({tag, "_wrmr_strobes"}, 32'(we_log.size() - wb + re_log.size() - rb), 32'd0);
  endtask

  task automatic runWrite(input string tag, input logic [15:0] a);
    logic [15:0] cur;
    int neff, base;
    tx_q = {8'h02, a[15:8], a[7:0]};
    foreach (dq[i]) tx_q.push_back(dq[i]);
    base = we_log.size();
    applyStimulus(0, 8'h00);
    neff = (ref_mode[7:6] == 2'b00) ? 1 : dq.size();
    checkOutput({tag, "_we_count"}, 32'(we_log.size() - base), 32'(neff));
    cur = a;
    for (int i = 0; i < neff; i++) begin
      if (base + i < we_log.size()) begin
        checkOutput({tag, "_we_addr"}, 32'(we_log[base+i][23:8]), 32'(cur));
        checkOutput({tag, "_we_data"}, 32'(we_log[base+i][7:0]), 32'(dq[i]));
      end
      ref_mem[cur] = dq[i];
      cur = refNext(cur);
    end
    checkIdle(tag);
  endtask

  task automatic runRead(input string tag, input logic [15:0] a, input int n);
    logic [15:0] cur;
    int base;
    logic bm;
    bm = (ref_mode[7:6] == 2'b00);
    tx_q = {8'h03, a[15:8], a[7:0]};
    for (int i = 0; i < n; i++) tx_q.push_back(8'h00);
    base = re_log.size();
    applyStimulus(0, 8'h00);
    for (int i = 0; i < 3; i++) checkOutput({tag, "_oe_hdr"}, 32'(oe_any_q[i]), 32'd0);
    cur = a;
    for (int i = 0; i < n; i++) begin
      if (bm && i > 0) begin
        checkOutput({tag, "_rd_data_ign"}, 32'(rx_q[3+i]), 32'd0);
        checkOutput({tag, "_oe_ign"}, 32'(oe_any_q[3+i]), 32'd0);
      end else begin
        checkOutput({tag, "_rd_data"}, 32'(rx_q[3+i]), 32'(ref_mem[cur]));
        checkOutput({tag, "_oe_data"}, 32'(oe_all_q[3+i]), 32'd1);
        if (base + i < re_log.size())
          checkOutput({tag, "_re_addr"}, 32'(re_log[base+i]), 32'(cur));
      end
      cur = refNext(cur);
    end
    if (bm) checkOutput({tag, "_re_count"}, 32'(re_log.size() - base), 32'd1);
    else    checkOutput({tag, "_re_min"}, 32'(re_log.size() - base >= n), 32'd1);
    checkIdle(tag);
  endtask

  initial begin
    logic [7:0]  m;
    logic [15:0] a;
    logic        mo, oeo;
    int          n, wb, rb;

    for (int i = 0; i < 65536; i++) ref_mem[i] = seedByte(16'(i));

    repeat (3) @(posedge clk);
    #2;
    checkReset("reset");
    reset = 1'b0;
    repeat (4) @(posedge clk);

    dq = {8'hA5};
    runWrite("wr1234", 16'h1234);
    checkOutput("wr1234_mode", 32'(mode_reg), 32'h40);
    checkOutput("busy_during_xfer", 32'(busy_mid), 32'd1);

    dq = {8'h11, 8'h22};
    runWrite("preload10", 16'h0010);
    runRead("rd0010", 16'h0010, 2);

    dq = {8'h01, 8'h02};
    runWrite("wrFFFF", 16'hFFFF);

    setMode("page", 8'h80);
    dq = {8'h31, 8'h32, 8'h33};
    runWrite("page3E", 16'h003E);
    tx_q = {8'h05, 8'h00};
    applyStimulus(0, 8'h00);
    checkOutput("rdmr_value", 32'(rx_q[1]), 32'h80);

    setMode("byte", 8'h00);
    runRead("byte05", 16'h0005, 2);

    setMode("seq", 8'h40);
    wb = we_log.size();
    tx_q = {8'h02, 8'h00, 8'h50};
    applyStimulus(5, 8'hC3);
    checkOutput("partial_we_count", 32'(we_log.size() - wb), 32'd0);

    wb = we_log.size();
    rb = re_log.size();
    tx_q = {8'hFF, 8'h00, 8'h00};
    applyStimulus(0, 8'h00);
    checkOutput("unk_strobes", 32'(we_log.size() - wb + re_log.size() - rb), 32'd0);
    checkOutput("unk_miso", 32'(rx_q[1] | rx_q[2]), 32'd0);
    checkOutput("unk_oe", 32'(oe_any_q[1] | oe_any_q[2]), 32'd0);

    for (int t = 0; t < 12; t++) begin
      m = 8'($urandom_range(3)) << 6;
      setMode("rnd", m);
      a = 16'($urandom);
      if ($urandom_range(1) == 1) a[4:0] = 5'h1E;
      n = $urandom_range(1, 4);
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
      runWrite("rnd_wr", a);
      runRead("rnd_rd", a, n);
    end

    setMode("pre_abort", 8'h40);
    @(posedge clk);
    #2 spi_cs_n = 1'b0;
    tx_q = {8'h03, 8'h00, 8'h10};
    foreach (tx_q[k])
      for (int i = 7; i >= 0; i--) spiBit(tx_q[k][i], mo, oeo);
    for (int i = 0; i < 3; i++) spiBit(1'b0, mo, oeo);
    checkOutput("abort_mid_oe", 32'(spi_miso_oe), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    checkReset("abort");
    ref_mode = 8'h40;
    spi_cs_n = 1'b1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    checkIdle("post_abort");

    checkOutput("we_re_overlap", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
